// File: rtl/mem_dma_if.sv
// Bundle between mem_dma and its requester / byte-wide data memory.
// The slave modport is the DMA engine's view; master is the requester plus memory side.
interface mem_dma_if;
  logic       start;
  logic [1:0] op;
  logic [7:0] src;
  logic [7:0] dst;
  logic [7:0] len;
  logic [7:0] fill_val;
  logic [7:0] mem_rdata;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic       mem_rd_en;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       done;
  logic [7:0] checksum;

  modport slave (
    input  start, op, src, dst, len, fill_val, mem_rdata,
    output mem_addr, mem_wr_en, mem_rd_en, mem_wdata, busy, done, checksum
  );

  modport master (
    output start, op, src, dst, len, fill_val, mem_rdata,
    input  mem_addr, mem_wr_en, mem_rd_en, mem_wdata, busy, done, checksum
  );
endinterface

// File: rtl/mem_dma.sv
// Byte DMA over a 256-byte data memory: copy, fill and checksum.
// Moore FSM; all memory-side outputs decode purely from registered state.
module mem_dma (
  input  logic       clk,
  input  logic       reset,
  mem_dma_if.slave   bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_e;

  localparam logic [1:0] OP_COPY  = 2'b00;
  localparam logic [1:0] OP_FILL  = 2'b01;
  localparam logic [1:0] OP_CKSUM = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  state_e     state_q;
  logic [1:0] op_q;
  logic [7:0] src_q, dst_q, len_q, fill_q;
  logic [7:0] i_q, buf_q, acc_q, cks_q;
  logic       busy_q, done_q;

  logic [7:0] i_d, acc_d;
  logic       last;

  assign i_d   = i_q + 8'd1;
  assign acc_d = acc_q + bus.mem_rdata;
  assign last  = (i_d == len_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_COPY;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      i_q     <= '0;
      buf_q   <= '0;
      acc_q   <= '0;
      cks_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            src_q  <= bus.src;
            dst_q  <= bus.dst;
            len_q  <= bus.len;
            fill_q <= bus.fill_val;
            i_q    <= '0;
            acc_q  <= '0;
            busy_q <= 1'b1;
            // Empty and reserved requests still produce a done pulse
            if (bus.len == 8'd0 || bus.op == OP_RSVD) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (bus.op == OP_FILL) begin
              state_q <= WRITE;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (op_q == OP_COPY) begin
            buf_q   <= bus.mem_rdata;
            state_q <= WRITE;
          end else begin
            acc_q <= acc_d;
            i_q   <= i_d;
            if (last) begin
              cks_q   <= acc_d;
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        WRITE: begin
          i_q <= i_d;
          if (last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (op_q == OP_COPY) begin
            state_q <= READ;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_rd_en = (state_q == READ);
  assign bus.mem_wr_en = (state_q == WRITE);
  assign bus.mem_addr  = (state_q == READ)  ? src_q + i_q :
                         (state_q == WRITE) ? dst_q + i_q : 8'd0;
  assign bus.mem_wdata = (state_q != WRITE) ? 8'd0 :
                         (op_q == OP_FILL)  ? fill_q : buf_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.checksum  = cks_q;
endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma: vector table of whole operations plus
// hand sequences for reset abort, reset/start priority and ignored starts.
module tb_mem_dma;
  logic clk = 1'b0;
  logic reset;
  mem_dma_if bus ();

  mem_dma dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Memory model: default pattern a^3C plus up to four preloaded bytes
  logic [7:0]       mem [256];
  logic             init_req = 1'b0;
  int               ld_np = 0;
  logic [3:0][7:0]  ld_pa = '0, ld_pv = '0;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (init_req) begin
      for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h3C;
      for (int k = 0; k < 4; k++) if (k < ld_np) mem[ld_pa[k]] = ld_pv[k];
    end else if (bus.mem_wr_en) begin
      mem[bus.mem_addr] = bus.mem_wdata;
    end
  end

  int done_cnt = 0, rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.mem_rd_en) rd_cnt++;
    if (bus.mem_wr_en) wr_cnt++;
    if (bus.mem_rd_en && bus.mem_wr_en) both_cnt++;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mem_load(input int np, input logic [3:0][7:0] pa, input logic [3:0][7:0] pv);
    @(negedge clk);
    ld_np = np; ld_pa = pa; ld_pv = pv; init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
  endtask

  // Drives one start pulse, then scrambles the request fields
  task automatic go(input logic [1:0] o, input logic [7:0] s, input logic [7:0] d,
                    input logic [7:0] l, input logic [7:0] f);
    @(negedge clk);
    bus.op = o; bus.src = s; bus.dst = d; bus.len = l; bus.fill_val = f;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op = ~o; bus.src = ~s; bus.dst = ~d; bus.len = ~l; bus.fill_val = ~f;
  endtask

  task automatic watch(output int done_at, output int busy_n, output logic [7:0] cks);
    done_at = 0; busy_n = 0; cks = 8'hXX;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done && done_at == 0) begin
        done_at = c;
        cks = bus.checksum;
        chk("done_bus_idle", {bus.mem_addr, bus.mem_wdata, bus.mem_wr_en, bus.mem_rd_en}, 0);
      end
      if (done_at != 0 && c >= done_at + 2) break;
    end
    if (done_at == 0) chk("done_timeout", 0, 1);
  endtask

  typedef struct {
    logic [1:0]      op;
    logic [7:0]      src, dst, len, fill;
    int              np;
    logic [3:0][7:0] pa, pv;
    int              nc;
    logic [3:0][7:0] ca, cv;
    int              exp_done, exp_rd, exp_wr;
    logic [7:0]      exp_cks;
  } vec_t;

  vec_t vt [9];

  initial begin
    int         done_at, busy_n, d0, r0, w0;
    logic [7:0] cks;

    vt[0] = '{2'b10, 8'h20, 8'h00, 8'd3, 8'h00, 3, {8'h00, 8'h22, 8'h21, 8'h20}, {8'h00, 8'h01, 8'h20, 8'hF0},
              0, '0, '0, 4, 3, 0, 8'h11};
    vt[1] = '{2'b01, 8'h00, 8'hFE, 8'd3, 8'h5A, 0, '0, '0,
              4, {8'h01, 8'h00, 8'hFF, 8'hFE}, {8'h3D, 8'h5A, 8'h5A, 8'h5A}, 4, 0, 3, 8'h11};
    vt[2] = '{2'b00, 8'h10, 8'h80, 8'd4, 8'h00, 4, {8'h13, 8'h12, 8'h11, 8'h10}, {8'hDD, 8'hCC, 8'hBB, 8'hAA},
              4, {8'h83, 8'h82, 8'h81, 8'h80}, {8'hDD, 8'hCC, 8'hBB, 8'hAA}, 9, 4, 4, 8'h11};
    vt[3] = '{2'b00, 8'h10, 8'h80, 8'd0, 8'h00, 0, '0, '0,
              1, {8'h00, 8'h00, 8'h00, 8'h80}, {8'h00, 8'h00, 8'h00, 8'hBC}, 1, 0, 0, 8'h11};
    vt[4] = '{2'b11, 8'h10, 8'h80, 8'd5, 8'h00, 0, '0, '0,
              1, {8'h00, 8'h00, 8'h00, 8'h80}, {8'h00, 8'h00, 8'h00, 8'hBC}, 1, 0, 0, 8'h11};
    vt[5] = '{2'b00, 8'h40, 8'h41, 8'd3, 8'h00, 3, {8'h00, 8'h42, 8'h41, 8'h40}, {8'h00, 8'h33, 8'h22, 8'h11},
              4, {8'h43, 8'h42, 8'h41, 8'h40}, {8'h11, 8'h11, 8'h11, 8'h11}, 7, 3, 3, 8'h11};
    vt[6] = '{2'b10, 8'hFF, 8'h00, 8'd2, 8'h00, 2, {8'h00, 8'h00, 8'h00, 8'hFF}, {8'h00, 8'h00, 8'h90, 8'h80},
              0, '0, '0, 3, 2, 0, 8'h10};
    vt[7] = '{2'b00, 8'hFE, 8'h50, 8'd3, 8'h00, 3, {8'h00, 8'h00, 8'hFF, 8'hFE}, {8'h00, 8'h03, 8'h02, 8'h01},
              4, {8'h53, 8'h52, 8'h51, 8'h50}, {8'h6F, 8'h03, 8'h02, 8'h01}, 7, 3, 3, 8'h10};
    vt[8] = '{2'b01, 8'h00, 8'h07, 8'd1, 8'hC3, 0, '0, '0,
              2, {8'h00, 8'h00, 8'h08, 8'h07}, {8'h00, 8'h00, 8'h34, 8'hC3}, 2, 0, 1, 8'h10};

    reset = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.src = '0; bus.dst = '0; bus.len = '0; bus.fill_val = '0;
    mem_load(0, '0, '0);
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_mem_bus", {bus.mem_addr, bus.mem_wdata, bus.mem_wr_en, bus.mem_rd_en}, 0);
    chk("rst_checksum", bus.checksum, 0);
    reset = 1'b0;

    for (int v = 0; v < 9; v++) begin
      mem_load(vt[v].np, vt[v].pa, vt[v].pv);
      d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt;
      go(vt[v].op, vt[v].src, vt[v].dst, vt[v].len, vt[v].fill);
      watch(done_at, busy_n, cks);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_cycle", v), done_at, vt[v].exp_done);
      chk($sformatf("v%0d_busy_cycles", v), busy_n, vt[v].exp_done);
      chk($sformatf("v%0d_done_pulses", v), done_cnt - d0, 1);
      chk($sformatf("v%0d_rd_pulses", v), rd_cnt - r0, vt[v].exp_rd);
      chk($sformatf("v%0d_wr_pulses", v), wr_cnt - w0, vt[v].exp_wr);
      chk($sformatf("v%0d_checksum", v), cks, vt[v].exp_cks);
      for (int k = 0; k < vt[v].nc; k++)
        chk($sformatf("v%0d_mem_%0h", v, vt[v].ca[k]), mem[vt[v].ca[k]], vt[v].cv[k]);
    end

    // Reset in cycle 3 of a len=4 copy: only the first byte lands
    mem_load(4, {8'h13, 8'h12, 8'h11, 8'h10}, {8'hDD, 8'hCC, 8'hBB, 8'hAA});
    d0 = done_cnt; w0 = wr_cnt;
    go(2'b00, 8'h10, 8'h80, 8'd4, 8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_done_pulses", done_cnt - d0, 0);
    chk("abort_wr_pulses", wr_cnt - w0, 1);
    chk("abort_mem_80", mem[8'h80], 8'hAA);
    chk("abort_mem_81", mem[8'h81], 8'hBD);
    chk("abort_mem_82", mem[8'h82], 8'hBE);
    chk("abort_mem_83", mem[8'h83], 8'hBF);
    chk("abort_checksum", bus.checksum, 0);

    // Reset wins over start on the same edge
    d0 = done_cnt; w0 = wr_cnt;
    @(negedge clk);
    reset = 1'b1; bus.start = 1'b1; bus.op = 2'b01; bus.dst = 8'hC0; bus.len = 8'd2; bus.fill_val = 8'h99;
    @(negedge clk);
    chk("rst_prio_busy", bus.busy, 0);
    reset = 1'b0; bus.start = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_prio_done_pulses", done_cnt - d0, 0);
    chk("rst_prio_wr_pulses", wr_cnt - w0, 0);

    // Start held high while busy and through the DONE cycle is ignored
    mem_load(0, '0, '0);
    d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt;
    go(2'b01, 8'h00, 8'h90, 8'd3, 8'h77);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.src = 8'h10; bus.dst = 8'hA0; bus.len = 8'd8;
    @(negedge clk);
    @(negedge clk);
    chk("restart_done_c4", bus.done, 1);
    @(negedge clk);
    chk("restart_busy_c5", bus.busy, 0);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("restart_done_pulses", done_cnt - d0, 1);
    chk("restart_wr_pulses", wr_cnt - w0, 3);
    chk("restart_rd_pulses", rd_cnt - r0, 0);
    chk("restart_mem_90", mem[8'h90], 8'h77);
    chk("restart_mem_92", mem[8'h92], 8'h77);
    chk("restart_mem_93", mem[8'h93], 8'hAF);
    chk("restart_mem_A0", mem[8'hA0], 8'h9C);

    chk("rd_wr_overlap", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
